conv_host_if: RTL and testbench
===============================

# conv_host_if

Host-side counterpart of the convolution engine's memory interface. It loads a 64x64 image of 20-bit words from an input stream and raises `ready` to start the engine. While the engine is busy, it answers image reads on `iaddr`/`idata` and serves layer-memory writes and reads on `cwr`/`crd`/`csel`. When `busy` falls, it streams both result layers back out. It sits between the system data path and the engine, taking the place of the contest testbench memories in silicon.

## Interface
Parameters:
- `DW`, 20, data word width (image, L0, L1).
- `IMG_AW`, 12, image/L0 address width (4096 words).
- `L1_AW`, 10, L1 address width (1024 words, 32x32 max-pool result).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  image word valid.
- `in_ready`  out  1  image word accepted when `in_valid & in_ready`.
- `in_data`  in  DW  image word, raster order, address 0 first.
- `ready`  out  1  start request to engine.
- `busy`  in  1  engine busy.
- `iaddr`  in  IMG_AW  image read address.
- `idata`  out  DW  image read data.
- `cwr`  in  1  layer write strobe.
- `caddr_wr`  in  IMG_AW  layer write address.
- `cdata_wr`  in  DW  layer write data.
- `crd`  in  1  layer read strobe.
- `caddr_rd`  in  IMG_AW  layer read address.
- `cdata_rd`  out  DW  layer read data.
- `csel`  in  3  layer select: 3'b001 = L0, 3'b011 = L1; every other code is illegal.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  result word accepted when `out_valid & out_ready`.
- `out_data`  out  DW  result word.
- `out_sel`  out  1  0 = L0 word, 1 = L1 word.
- `out_last`  out  1  final L1 word.
- `err`  out  1  sticky protocol error.

## Operation
- FSM states: LOAD, START, RUN, DUMP. Reset state is LOAD.
- LOAD:
  - `in_ready` = 1.
  - Each accepted word is written to image RAM at `load_cnt`, and `load_cnt` increments.
  - On the accept of word 4095, go to START.
- START:
  - `ready` = 1.
  - When `busy` is sampled 1, clear `ready` on that edge and go to RUN.
- RUN:
  - Image RAM is read at `iaddr` every cycle.
  - `cwr` writes `cdata_wr` to the bank selected by `csel`.
  - `crd` reads from the bank selected by `csel`; `cdata_rd` is updated only when `crd` was high, otherwise it holds.
  - A falling edge of `busy` (1 then 0 on consecutive samples) moves to DUMP.
- DUMP:
  - Stream L0 addresses 0..4095 with `out_sel` = 0, then L1 addresses 0..1023 with `out_sel` = 1.
  - `out_last` is asserted with L1 word 1023.
  - After the last handshake, return to LOAD with `load_cnt` = 0.
- Bank rules:
  - An L1 access uses `caddr_[9:0]`. If bits [11:10] are nonzero, set `err`; the write is dropped and `cdata_rd` holds.
  - An illegal `csel` with `cwr` or `crd` high sets `err`; no access is performed.
  - `cwr` or `crd` outside RUN sets `err` and is ignored.
  - `cwr` and `crd` in the same cycle are legal. When both hit the same bank and address, the read returns the old value (read-first).
- `err` is cleared only by `reset`.
- Memories are not cleared by reset. Their contents are undefined until written.

## Timing
- Reset values: `in_ready` = 1, `ready` = 0, `idata` = 0, `cdata_rd` = 0, `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `out_last` = 0, `err` = 0.
- Read latency is one cycle. `idata` after edge k equals image[`iaddr` sampled at edge k]; `cdata_rd` behaves the same way for `caddr_rd`.
- `ready` rises on the edge that accepts image word 4095, and falls on the first edge that samples `busy` = 1.
- `busy` already high while in START counts as acknowledged on the next edge.
- DUMP:
  - `out_valid` rises one cycle after entering DUMP.
  - `out_valid`, `out_data`, `out_sel` and `out_last` hold stable while `out_ready` = 0.
  - With `out_ready` held at 1, one word transfers per cycle. The next word is prefetched so there are no bubbles, including at the L0→L1 boundary.
- `in_valid` outside LOAD is ignored (`in_ready` = 0).
- Asynchronous reset in any state:
  - FSM goes to LOAD immediately and all counters clear.
  - An in-progress DUMP is abandoned, and `out_valid` drops asynchronously.

## Structure
- Package `conv_host_pkg`:
  - state enum;
  - `CSEL_L0` = 3'b001 and `CSEL_L1` = 3'b011;
  - `IMG_DEPTH` = 4096 and `L1_DEPTH` = 1024.
- Sub-module `conv_sp_ram`:
  - parameters: depth and width;
  - synchronous write, registered read, read-first.
  - Instantiated three times: image, L0, L1.
  - The L0 and L1 read ports are muxed between the engine `crd` path (RUN) and the dump counter (DUMP).

## Test plan
- Load words `i*3` for i = 0..4095 → `ready` = 1 on the edge after word 4095; assert `busy` → `ready` = 0 on the next edge.
- RUN with `iaddr` = 130 → `idata` = 390 one cycle later; `iaddr` changed every cycle → `idata` tracks with one-cycle lag.
- `cwr` to L0 addr 5 with 20'h0A89E, then `crd` L0 addr 5 → `cdata_rd` = 20'h0A89E. Simultaneous `cwr` of 20'h00001 and `crd` at the same address → old value 20'h0A89E returned, then 20'h00001 on the next read.
- `cwr` with `csel` = 3'b010, and `cwr` to L1 with `caddr_wr` = 1024 → `err` = 1; L1 address 0 unchanged.
- Drop `busy` → full dump of 5120 words. `out_ready` toggling 1/0 gives correct order, words 4096+ carry `out_sel` = 1, and `out_last` appears only on word 5119. FSM then returns to LOAD.
- Assert `reset` mid-DUMP at word 2000 → `out_valid` = 0 and `in_ready` = 1. A new load then restarts cleanly.

Source files
------------

// File: rtl/conv_host_pkg.sv
// conv_host_pkg
// Shared types and constants for the convolution-engine host interface.
//   state_t        : host FSM state (LOAD -> START -> RUN -> DUMP -> LOAD)
//   CSEL_L0/CSEL_L1: legal layer-select codes on csel
//   IMG_DEPTH      : words in the image RAM and in L0 (64x64)
//   L1_DEPTH       : words in L1 (32x32 max-pool result)
//   DUMP_WORDS     : total words streamed out after the engine finishes
package conv_host_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  localparam int IMG_DEPTH  = 4096;
  localparam int L1_DEPTH   = 1024;
  localparam int DUMP_WORDS = IMG_DEPTH + L1_DEPTH;

  // Only the two layer codes address a bank; everything else is a protocol error.
  function automatic logic csel_legal(input logic [2:0] sel);
    return (sel == CSEL_L0) || (sel == CSEL_L1);
  endfunction

endpackage

// File: rtl/conv_sp_ram.sv
// conv_sp_ram
// One-write/one-read synchronous RAM with a registered, read-first output.
//   clk, reset : clock; reset clears only the read register, never the array
//   we, waddr, wdata : synchronous write
//   re, raddr        : read request; rdata loads mem[raddr] on the edge
//   rdata            : read register, holds its value while re is low
// A read and a write to the same address on one edge return the old word.
module conv_sp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 20,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking update of mem gives read-first behaviour on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_host_if.sv
// conv_host_if
// Host side of the convolution engine memory interface. Loads a 64x64 image
// from an input stream, requests a start, serves the engine's image and layer
// memory traffic while busy, then streams L0 followed by L1 back out.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data : image word stream, raster order
//   ready, busy           : start request to engine / engine busy
//   iaddr, idata          : image read port (1-cycle latency)
//   cwr, caddr_wr, cdata_wr : layer write port
//   crd, caddr_rd, cdata_rd : layer read port (1-cycle latency, holds when idle)
//   csel                  : layer select (CSEL_L0 / CSEL_L1)
//   out_valid/out_ready/out_data/out_sel/out_last : result word stream
//   err                   : sticky protocol error
//   state_dbg             : current FSM state for observation
// Stream handshake (both in_* and out_*): a word moves on a clock edge where
// valid and ready are both high; the source keeps valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module conv_host_if
  import conv_host_pkg::*;
#(
  parameter int DW     = 20,
  parameter int IMG_AW = 12,
  parameter int L1_AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              err,
  output state_t            state_dbg
);

  state_t            state;
  logic [IMG_AW-1:0] load_cnt;
  logic [IMG_AW:0]   dump_idx;   // next dump word to fetch, 0..DUMP_WORDS
  logic              busy_q;

  logic run, in_fire;
  logic wr_in_l1, rd_in_l1;
  logic cwr_l0, cwr_l1, crd_l0, crd_l1;
  logic err_set;
  logic dump_re, dump_re_l0, dump_re_l1;
  logic [IMG_AW-1:0] l0_raddr;
  logic [L1_AW-1:0]  l1_raddr;
  logic [DW-1:0]     l0_q, l1_q, live_rd;

  // cdata_rd ownership: the layer RAM read registers are shared with the dump,
  // so the last engine read result is frozen in cdata_hold once dumping starts.
  logic              rd_bank;
  logic              cdata_own;
  logic [DW-1:0]     cdata_hold;

  assign state_dbg = state;
  assign in_ready  = (state == ST_LOAD);
  assign in_fire   = in_valid & in_ready;
  assign run       = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Engine access decode
  // ---------------------------------------------------------------------------
  assign wr_in_l1 = (caddr_wr[IMG_AW-1:L1_AW] == '0);
  assign rd_in_l1 = (caddr_rd[IMG_AW-1:L1_AW] == '0);

  assign cwr_l0 = run & cwr & (csel == CSEL_L0);
  assign cwr_l1 = run & cwr & (csel == CSEL_L1) & wr_in_l1;
  assign crd_l0 = run & crd & (csel == CSEL_L0);
  assign crd_l1 = run & crd & (csel == CSEL_L1) & rd_in_l1;

  assign err_set = ((cwr | crd) & ~run)
                 | (run & (cwr | crd) & ~csel_legal(csel))
                 | (run & (csel == CSEL_L1) & ((cwr & ~wr_in_l1) | (crd & ~rd_in_l1)));

  // ---------------------------------------------------------------------------
  // Dump fetch: a fetch is issued whenever the output slot is empty or is being
  // drained this cycle, so the RAM read register acts as the output stage and
  // a stalled word simply stays in it.
  // ---------------------------------------------------------------------------
  assign dump_re    = (state == ST_DUMP) && (32'(dump_idx) < DUMP_WORDS)
                      && (!out_valid || out_ready);
  assign dump_re_l0 = dump_re & ~dump_idx[IMG_AW];
  assign dump_re_l1 = dump_re &  dump_idx[IMG_AW];

  assign l0_raddr = run ? caddr_rd : dump_idx[IMG_AW-1:0];
  assign l1_raddr = run ? caddr_rd[L1_AW-1:0] : dump_idx[L1_AW-1:0];

  // ---------------------------------------------------------------------------
  // Memories
  // ---------------------------------------------------------------------------
  conv_sp_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
    .clk   (clk),
    .reset (reset),
    .we    (in_fire),
    .waddr (load_cnt),
    .wdata (in_data),
    .re    (run),
    .raddr (iaddr),
    .rdata (idata)
  );

  conv_sp_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_l0 (
    .clk   (clk),
    .reset (reset),
    .we    (cwr_l0),
    .waddr (caddr_wr),
    .wdata (cdata_wr),
    .re    (crd_l0 | dump_re_l0),
    .raddr (l0_raddr),
    .rdata (l0_q)
  );

  conv_sp_ram #(.DEPTH(L1_DEPTH), .WIDTH(DW)) u_l1 (
    .clk   (clk),
    .reset (reset),
    .we    (cwr_l1),
    .waddr (caddr_wr[L1_AW-1:0]),
    .wdata (cdata_wr),
    .re    (crd_l1 | dump_re_l1),
    .raddr (l1_raddr),
    .rdata (l1_q)
  );

  // ---------------------------------------------------------------------------
  // Engine read data
  // ---------------------------------------------------------------------------
  assign live_rd  = rd_bank ? l1_q : l0_q;
  assign cdata_rd = cdata_own ? live_rd : cdata_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank    <= 1'b0;
      cdata_own  <= 1'b1;
      cdata_hold <= '0;
    end else begin
      cdata_hold <= cdata_rd;
      if (crd_l0 | crd_l1) begin
        cdata_own <= 1'b1;
        rd_bank   <= crd_l1;
      end else if (dump_re) begin
        cdata_own <= 1'b0;
      end
    end
  end

  // Result word comes straight out of the selected layer's read register.
  assign out_data = out_valid ? (out_sel ? l1_q : l0_q) : '0;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_LOAD;
      load_cnt  <= '0;
      dump_idx  <= '0;
      busy_q    <= 1'b0;
      ready     <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy_q <= busy;
      if (err_set) err <= 1'b1;

      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            load_cnt <= load_cnt + IMG_AW'(1);
            if (&load_cnt) begin
              state <= ST_START;
              ready <= 1'b1;
            end
          end
        end

        ST_START: begin
          if (busy) begin
            ready <= 1'b0;
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // busy_q is already 1 here because START leaves on a busy sample.
          if (busy_q && !busy) begin
            state    <= ST_DUMP;
            dump_idx <= '0;
          end
        end

        ST_DUMP: begin
          if (dump_re) begin
            dump_idx  <= dump_idx + (IMG_AW+1)'(1);
            out_valid <= 1'b1;
            out_sel   <= dump_idx[IMG_AW];
            out_last  <= (32'(dump_idx) == DUMP_WORDS - 1);
          end else if (out_valid && out_ready) begin
            // Nothing left to fetch, so this is the final handshake.
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_last  <= 1'b0;
            state     <= ST_LOAD;
            load_cnt  <= '0;
            dump_idx  <= '0;
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_host_if.sv
// tb_conv_host_if
// Directed bench for conv_host_if: image load/start handshake, RUN image and
// layer accesses, protocol errors, full result dump with back-pressure, and
// asynchronous reset in the middle of a dump.
module tb_conv_host_if;
  import conv_host_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic [2:0]  csel = 3'b001;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic        out_sel;
  logic        out_last;
  logic        err;
  state_t      state_dbg;

  conv_host_if dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .cwr       (cwr),
    .caddr_wr  (caddr_wr),
    .cdata_wr  (cdata_wr),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .csel      (csel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] m_l0 [4096];
  logic [19:0] m_l1 [1024];
  logic [21:0] exp_q [$];   // {out_sel, out_last, out_data}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input int mult, input int offs);
    for (int i = 0; i < 4096; i++) begin
      in_valid = 1'b1;
      in_data  = 20'(i * mult + offs);
      tick();
      if (i == 4094) begin
        check("ready_before_last", 32'(ready), 32'd0);
        check("in_ready_before_last", 32'(in_ready), 32'd1);
      end
    end
    in_valid = 1'b0;
    check("ready_after_load", 32'(ready), 32'd1);
    check("in_ready_after_load", 32'(in_ready), 32'd0);
  endtask

  task automatic lwrite(input logic [2:0] sel, input logic [11:0] a, input logic [19:0] d);
    csel = sel; caddr_wr = a; cdata_wr = d; cwr = 1'b1;
    tick();
    cwr = 1'b0;
  endtask

  task automatic lread(input logic [2:0] sel, input logic [11:0] a);
    csel = sel; caddr_rd = a; crd = 1'b1;
    tick();
    crd = 1'b0;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int a = 0; a < 4096; a++) exp_q.push_back({1'b0, 1'b0, m_l0[a]});
    for (int a = 0; a < 1024; a++) exp_q.push_back({1'b1, (a == 1023), m_l1[a]});
  endtask

  // Accepts stop_at words; out_ready toggles until toggle_until words have moved.
  task automatic run_dump(input int stop_at, input int toggle_until);
    int n = 0;
    int cyc = 0;
    while (n < stop_at && cyc < 20000) begin
      out_ready = (n < toggle_until) ? cyc[0] : 1'b1;
      if (out_valid) begin
        check("dump_word", {10'b0, out_sel, out_last, out_data},
              (exp_q.size() > 0) ? {10'b0, exp_q[0]} : 32'hffff_ffff);
        if (out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n++;
        end
      end else if (n > 0) begin
        check("no_bubble", 32'(out_valid), 32'd1);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("dump_count", n, stop_at);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [19:0] prev;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_idata", 32'(idata), 32'd0);
    check("rst_cdata_rd", 32'(cdata_rd), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_LOAD));
    reset = 1'b0;
    tick();

    // Load i*3 and start the engine.
    load_image(3, 0);
    in_valid = 1'b1; in_data = 20'd777;   // ignored outside LOAD
    tick();
    in_valid = 1'b0;
    check("start_in_ready", 32'(in_ready), 32'd0);
    check("start_ready_hold", 32'(ready), 32'd1);
    check("start_state", 32'(state_dbg), 32'(ST_START));
    busy = 1'b1;
    tick();
    check("ready_drop", 32'(ready), 32'd0);
    check("run_state", 32'(state_dbg), 32'(ST_RUN));

    // Image reads.
    iaddr = 12'd130;
    tick();
    check("idata_130", 32'(idata), 32'd390);
    for (int j = 0; j < 8; j++) begin
      iaddr = 12'(j * 511 + 3);
      tick();
      check("idata_track", 32'(idata), 32'(3 * (j * 511 + 3)));
    end
    prev = idata;
    iaddr = 12'd10;
    #1;
    check("idata_lag", 32'(idata), 32'(prev));
    tick();
    check("idata_10", 32'(idata), 32'd30);

    // Fill both layers so every dumped word is defined.
    for (int a = 0; a < 4096; a++) begin
      m_l0[a] = 20'(a * 7 + 11);
      lwrite(CSEL_L0, 12'(a), m_l0[a]);
    end
    for (int a = 0; a < 1024; a++) begin
      m_l1[a] = 20'(a * 13) ^ 20'h80000;
      lwrite(CSEL_L1, 12'(a), m_l1[a]);
    end

    // Layer write/read, hold, read-first collision.
    lwrite(CSEL_L0, 12'd5, 20'h0A89E);
    m_l0[5] = 20'h0A89E;
    lread(CSEL_L0, 12'd5);
    check("l0_rd_5", 32'(cdata_rd), 32'h0A89E);
    tick();
    check("l0_rd_hold", 32'(cdata_rd), 32'h0A89E);
    csel = CSEL_L0; caddr_wr = 12'd5; cdata_wr = 20'h00001; cwr = 1'b1;
    caddr_rd = 12'd5; crd = 1'b1;
    tick();
    cwr = 1'b0; crd = 1'b0;
    m_l0[5] = 20'h00001;
    check("l0_read_first", 32'(cdata_rd), 32'h0A89E);
    lread(CSEL_L0, 12'd5);
    check("l0_rd_new", 32'(cdata_rd), 32'h00001);
    lread(CSEL_L1, 12'd1023);
    check("l1_rd_1023", 32'(cdata_rd), 32'(20'h80000 ^ 20'(1023 * 13)));
    check("err_clean", 32'(err), 32'd0);

    // Protocol errors.
    lwrite(3'b010, 12'd0, 20'hFFFFF);
    check("err_bad_csel", 32'(err), 32'd1);
    lwrite(CSEL_L1, 12'd1024, 20'hBEEF0);
    lread(CSEL_L1, 12'd0);
    check("l1_addr0_kept", 32'(cdata_rd), 32'h80000);
    lread(CSEL_L1, 12'd2047);
    check("l1_bad_rd_hold", 32'(cdata_rd), 32'h80000);
    check("err_sticky", 32'(err), 32'd1);

    // Full dump with back-pressure, then steady out_ready across L0->L1.
    busy = 1'b0;
    tick();
    check("dump_state", 32'(state_dbg), 32'(ST_DUMP));
    check("dump_first_cycle", 32'(out_valid), 32'd0);
    build_exp();
    run_dump(5120, 4090);
    check("dump_done_valid", 32'(out_valid), 32'd0);
    check("dump_done_state", 32'(state_dbg), 32'(ST_LOAD));
    check("dump_done_in_ready", 32'(in_ready), 32'd1);
    check("cdata_rd_after_dump", 32'(cdata_rd), 32'h80000);

    // Second session: reset at word 2000 of the dump.
    load_image(5, 2);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check("dump2_state", 32'(state_dbg), 32'(ST_DUMP));
    build_exp();
    run_dump(2000, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_state", 32'(state_dbg), 32'(ST_LOAD));
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Layer write while loading is a protocol error.
    lwrite(CSEL_L0, 12'd0, 20'h12345);
    check("err_cwr_in_load", 32'(err), 32'd1);

    // Fresh load must start from address 0.
    load_image(1, 1);
    busy = 1'b1;
    tick();
    check("run3_state", 32'(state_dbg), 32'(ST_RUN));
    iaddr = 12'd0;
    tick();
    check("reload_idata_0", 32'(idata), 32'd1);
    iaddr = 12'd4095;
    tick();
    check("reload_idata_4095", 32'(idata), 32'd4096);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
